// File: rtl/pc_seq_pkg.sv
// Shared constants for the program-counter sequencer: FSM state codes and the
// branch-select (BS1/BS0) encodings used by the decoder and branch_decide.
package pc_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_WAIT   = 3'd3;
  localparam state_t S_UPDATE = 3'd4;
  localparam state_t S_HALT   = 3'd5;

  localparam logic [1:0] BS_INC  = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_REL  = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

endpackage

// File: rtl/pc_sequencer_branch_decide.sv
// Branch decision: maps bs/ps/z to a taken flag and next-PC source (sel uses BS_* codes).
// Purely combinational, zero latency; no handshake.
module branch_decide
  import pc_seq_pkg::*;
(
  input  logic       ps,
  input  logic       z,
  input  logic [1:0] bs,
  output logic       take,
  output logic [1:0] sel
);

  // sel names the PC source: BS_INC = pc+1, BS_REL = pc+offset, BS_JMP = absolute.
  always_comb begin
    take = 1'b0;
    sel  = BS_INC;
    case (bs)
      BS_COND: begin
        if (z == ps) begin
          take = 1'b1;
          sel  = BS_REL;
        end
      end
      BS_REL: begin
        take = 1'b1;
        sel  = BS_REL;
      end
      BS_JMP: begin
        take = 1'b1;
        sel  = BS_JMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: fetch (req/ack), exec start/done, PC resolve; 4 cycles/instr minimum.
// Stalls indefinitely on imem_ack / exec_done. PC_SEQ_BRANCH_STATS_EN adds taken/retired counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              AW       = 8,
  parameter int              IW       = 16,
  parameter int              OW       = 6,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          halt_req,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ir,
  output logic          exec_start,
  input  logic          exec_done,
  input  logic          z_flag,
  input  logic [1:0]    bs,
  input  logic          ps,
  input  logic [OW-1:0] br_offset,
  input  logic [AW-1:0] jmp_addr,
  output logic [AW-1:0] pc,
  output logic          branch_taken,
  output logic          busy,
  output logic          halted
`ifdef PC_SEQ_BRANCH_STATS_EN
  ,
  output logic [15:0]   taken_cnt,
  output logic [15:0]   retired_cnt
`endif
);

  state_t        state, state_nxt;
  logic          z_latched;
  logic          take;
  logic [1:0]    sel;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] pc_nxt;

  branch_decide u_branch_decide (
    .ps   (ps),
    .z    (z_latched),
    .bs   (bs),
    .take (take),
    .sel  (sel)
  );

  assign off_ext = AW'($signed(br_offset));

  always_comb begin
    case (sel)
      BS_REL:  pc_nxt = pc + off_ext;
      BS_JMP:  pc_nxt = jmp_addr;
      default: pc_nxt = pc + AW'(1);
    endcase
  end

  // run/halt_req only matter in IDLE and UPDATE, so a mid-instruction drop still retires it.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WAIT;
      S_WAIT:   if (exec_done) state_nxt = S_UPDATE;
      S_UPDATE: begin
        if (halt_req)  state_nxt = S_HALT;
        else if (!run) state_nxt = S_IDLE;
        else           state_nxt = S_FETCH;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      z_latched <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (state == S_WAIT && exec_done) z_latched <= z_flag;
      if (state == S_UPDATE) pc <= pc_nxt;
    end
  end

  assign imem_req     = (state == S_FETCH);
  assign imem_addr    = pc;
  assign exec_start   = (state == S_EXEC);
  assign branch_taken = (state == S_UPDATE) && take;
  assign busy         = (state != S_IDLE) && (state != S_HALT);
  assign halted       = (state == S_HALT);

`ifdef PC_SEQ_BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (branch_taken && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
      if (state == S_UPDATE && retired_cnt != 16'hFFFF) retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed PCs; counter checks when
// PC_SEQ_BRANCH_STATS_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, halt_req;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, pc, jmp_addr;
  logic [15:0] imem_rdata, ir;
  logic        exec_start, exec_done, z_flag, ps;
  logic [1:0]  bs;
  logic [5:0]  br_offset;
  logic        branch_taken, busy, halted;
`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0] taken_cnt, retired_cnt;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(.AW(8), .IW(16), .OW(6), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .halt_req     (halt_req),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .exec_start   (exec_start),
    .exec_done    (exec_done),
    .z_flag       (z_flag),
    .bs           (bs),
    .ps           (ps),
    .br_offset    (br_offset),
    .jmp_addr     (jmp_addr),
    .pc           (pc),
    .branch_taken (branch_taken),
    .busy         (busy),
    .halted       (halted)
`ifdef PC_SEQ_BRANCH_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .retired_cnt  (retired_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_exit = 0;
  int exp_taken = 0;
  int exp_retired = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full instruction with the given decoder fields and handshake delays.
  task automatic do_instr(input string tag, input logic [1:0] b, input logic p, input logic zf,
                          input logic [5:0] off, input logic [7:0] ja,
                          input int ack_dly, input int done_dly, input logic hr, input logic drop_run,
                          input logic [7:0] exp_pc, input logic exp_tk, input logic chk_lat);
    logic [7:0]  addr0;
    logic [15:0] word;
    int          starts;
    int          guard;
    bs = b; ps = p; br_offset = off; jmp_addr = ja;
    guard = 0;
    while (!imem_req && guard < 20) begin
      step();
      guard++;
    end
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    addr0 = imem_addr;
    word  = {8'hC3, addr0};
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk({tag, "_req_hold"}, 32'({imem_req, imem_addr}), 32'({1'b1, addr0}));
    end
    imem_ack = 1'b1; imem_rdata = word;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    chk({tag, "_ir"}, 32'(ir), 32'(word));
    starts = int'(exec_start);
    exec_done = (done_dly > 0);
    z_flag = ~zf;
    step();
    exec_done = 1'b0;
    for (int i = 0; i < done_dly; i++) begin
      starts += int'(exec_start);
      step();
    end
    starts += int'(exec_start);
    exec_done = 1'b1; z_flag = zf; halt_req = hr;
    if (drop_run) run = 1'b0;
    step();
    exec_done = 1'b0; z_flag = ~zf;
    chk({tag, "_taken"}, 32'(branch_taken), 32'(exp_tk));
    starts += int'(exec_start);
    chk({tag, "_starts"}, 32'(starts), 32'd1);
    step();
    halt_req = 1'b0;
    chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    if (chk_lat) chk({tag, "_lat"}, 32'(cyc - last_exit), 32'd4);
    last_exit = cyc;
    exp_retired++;
    if (exp_tk) exp_taken++;
`ifdef PC_SEQ_BRANCH_STATS_EN
    chk({tag, "_taken_cnt"}, 32'(taken_cnt), 32'(exp_taken));
    chk({tag, "_retired_cnt"}, 32'(retired_cnt), 32'(exp_retired));
`endif
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; z_flag = 1'b0; bs = 2'b00; ps = 1'b0; br_offset = '0; jmp_addr = '0;
    step(); step();
    chk("rst_pc", 32'(pc), 32'h00);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_outs", 32'({imem_req, exec_start, branch_taken, busy, halted}), 32'h0);
`ifdef PC_SEQ_BRANCH_STATS_EN
    chk("rst_cnts", 32'({taken_cnt, retired_cnt}), 32'h0);
`endif
    rst_n = 1'b1; run = 1'b1;

    //        tag      bs     ps    z     off    jmp    ack dn hr    drop  exp_pc tk    lat
    do_instr("inc0",  2'b00, 1'b0, 1'b0, 6'h00, 8'h00, 0, 0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    do_instr("inc1",  2'b00, 1'b0, 1'b0, 6'h00, 8'h00, 0, 0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
    do_instr("inc2",  2'b00, 1'b0, 1'b0, 6'h00, 8'h00, 0, 0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1);
    do_instr("jmp10", 2'b11, 1'b0, 1'b0, 6'h00, 8'h10, 0, 0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1);
    do_instr("bz_t",  2'b01, 1'b1, 1'b1, 6'h3D, 8'h00, 0, 0, 1'b0, 1'b0, 8'h0D, 1'b1, 1'b1);
    do_instr("jmp10b",2'b11, 1'b0, 1'b0, 6'h00, 8'h10, 0, 0, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1);
    do_instr("bz_nt", 2'b01, 1'b1, 1'b0, 6'h3D, 8'h00, 0, 0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1);
    do_instr("jmpFE", 2'b11, 1'b0, 1'b0, 6'h00, 8'hFE, 0, 0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1);
    do_instr("bnz_w", 2'b01, 1'b0, 1'b0, 6'h05, 8'h00, 0, 0, 1'b0, 1'b0, 8'h03, 1'b1, 1'b1);
    do_instr("jmp80", 2'b11, 1'b0, 1'b0, 6'h00, 8'h80, 0, 0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1);
    do_instr("jmp02", 2'b11, 1'b0, 1'b0, 6'h00, 8'h02, 0, 0, 1'b0, 1'b0, 8'h02, 1'b1, 1'b1);
    do_instr("rel_m4",2'b10, 1'b1, 1'b1, 6'h3C, 8'h00, 0, 0, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b1);
    do_instr("slow",  2'b00, 1'b0, 1'b0, 6'h00, 8'h00, 3, 2, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    do_instr("wrap",  2'b00, 1'b0, 1'b0, 6'h00, 8'h00, 0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    chk("idle_after_run_drop", 32'({busy, imem_req, halted}), 32'h0);
    step();
    chk("idle_stays", 32'({busy, imem_req, pc}), 32'h000);
    run = 1'b1;

    do_instr("halt",  2'b00, 1'b0, 1'b0, 6'h00, 8'h00, 0, 0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    chk("halted", 32'({halted, busy}), 32'h2);
    for (int i = 0; i < 5; i++) step();
    chk("halt_sticky", 32'({halted, busy, imem_req, pc}), 32'({1'b1, 1'b0, 1'b0, 8'h01}));

    rst_n = 1'b0;
    step();
    chk("rst_from_halt", 32'({halted, pc}), 32'h000);
    rst_n = 1'b1; run = 1'b1;
    exp_taken = 0; exp_retired = 0;
    do_instr("post_rst", 2'b00, 1'b0, 1'b0, 6'h00, 8'h00, 0, 0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
    chk("mid_fetch_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 32'(pc), 32'h00);
    chk("async_rst_outs", 32'({imem_req, busy, halted, exec_start}), 32'h0);
`ifdef PC_SEQ_BRANCH_STATS_EN
    chk("async_rst_cnts", 32'({taken_cnt, retired_cnt}), 32'h0);
`endif
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle program-counter controller for the RISC CPU.
- Drives instruction fetch over a req/ack handshake and holds the fetched word in the instruction register.
- Starts execution of each instruction and waits for the datapath to finish.
- Resolves the next PC from the decoder's branch-select fields (BS1/BS0, PS) and the datapath zero flag, using an internal branch-decision sub-module.
- Sits between the instruction memory, the instruction decoder and the datapath.

Parameters:
- AW, 8, PC / instruction-address width.
- IW, 16, instruction word width.
- OW, 6, signed branch-offset width (OW <= AW).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level enable; IDLE leaves to FETCH while high.
- halt_req  in  1  request to stop after the current instruction retires.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  AW  fetch address; always equals pc.
- imem_ack  in  1  fetch acknowledge; imem_rdata valid in the same cycle.
- imem_rdata  in  IW  fetched instruction word.
- ir  out  IW  instruction register.
- exec_start  out  1  one-cycle pulse that starts the datapath on ir.
- exec_done  in  1  datapath done; z_flag valid in the same cycle.
- z_flag  in  1  zero flag from the datapath.
- bs  in  2  branch select from the decoder; stable while in EXEC.
- ps  in  1  polarity select from the decoder.
- br_offset  in  OW  signed relative offset from the decoder.
- jmp_addr  in  AW  absolute jump target (register value).
- pc  out  AW  program counter.
- branch_taken  out  1  one-cycle pulse in UPDATE when a non-sequential PC is loaded.
- busy  out  1  high in any state other than IDLE or HALT.
- halted  out  1  high in HALT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc=RESET_PC, ir=0, z_latched=0.
  - All pulse/req outputs 0, busy=0, halted=0.
  - Reset asserted mid-fetch or mid-exec abandons the transaction immediately; no PC update.
- States: IDLE, FETCH, EXEC, WAIT, UPDATE, HALT.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: ir<=imem_rdata, go to EXEC.
  - No ack means stay; no timeout.
- EXEC: exec_start=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On exec_done=1: z_latched<=z_flag, go to UPDATE.
  - exec_done in the EXEC cycle itself is ignored.
- UPDATE (single cycle):
  - sel=0 (bs=00): pc<=pc+1.
  - bs=01: take = (z_latched == ps), i.e. PS=1 branches on zero and PS=0 branches on non-zero.
  - bs=10: unconditional relative branch; pc<=pc+sext(br_offset).
  - bs=11: pc<=jmp_addr.
  - Any taken branch (01 taken, 10, 11) pulses branch_taken=1.
  - Next state, in priority order: halt_req=1 -> HALT; else run=0 -> IDLE; else FETCH.
- HALT: sticky until reset; pc is frozen.
- Latency: minimum 4 cycles per instruction with a zero-wait ack and exec_done on the first WAIT cycle.
- Arithmetic:
  - All PC arithmetic is modulo 2^AW.
  - br_offset is sign-extended to AW.
  - Wrap examples: 0xFF+1=0x00; 0x02+(-4)=0xFE.
- Input sampling:
  - halt_req and run are sampled only in IDLE/UPDATE.
  - run dropping mid-instruction still completes that instruction.

Optional Feature:
- Macro PC_SEQ_BRANCH_STATS_EN.
- When defined:
  - Adds output taken_cnt[15:0], saturating at 0xFFFF.
  - Increments in the cycle branch_taken=1; reset to 0.
  - Adds output retired_cnt[15:0] with the same rules, incremented in every UPDATE.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package pc_seq_pkg holds:
  - the state enum (IDLE=0, FETCH=1, EXEC=2, WAIT=3, UPDATE=4, HALT=5, 3-bit);
  - the BS encodings BS_INC=2'b00, BS_COND=2'b01, BS_REL=2'b10, BS_JMP=2'b11.
- Sub-module branch_decide:
  - combinational; inputs ps, z, bs; outputs take and sel[1:0];
  - reusable by the CPU's standalone branch logic tests.

Test Plan:
- Reset, run=1, bs=00, zero-wait ack, exec_done on the first WAIT cycle -> pc 0,1,2 at each UPDATE exit, 4 cycles apart, branch_taken=0.
- pc=0x10, bs=01, ps=1, z=1, br_offset=-3 -> pc=0x0D, branch_taken pulse; repeat with z=0 -> pc=0x11, no pulse.
- bs=01, ps=0, z=0, offset=+5 at pc=0xFE -> pc=0x03 (wrap); bs=11, jmp_addr=0x80 -> pc=0x80.
- imem_ack delayed 3 cycles and exec_done delayed 2 cycles -> imem_req held with a constant imem_addr, exactly one exec_start pulse.
- halt_req=1 during WAIT -> PC updates, then HALT with halted=1 and run ignored; rst_n low mid-FETCH -> IDLE, pc=RESET_PC at once.
- PC_SEQ_BRANCH_STATS_EN defined, 3 taken branches out of 5 instructions -> taken_cnt=3, retired_cnt=5.
